// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative HI/LO multiply/divide unit.
//   - op encodings driven on opE by the Execute stage
//   - sequencer state type
//   - default operand width and the matching step-counter width
// Optional divider support is compiled in with `define MULDIV_DIV_EN.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

   localparam logic [1:0] MULTU = 2'b00;
   localparam logic [1:0] MULT  = 2'b01;
   localparam logic [1:0] DIVU  = 2'b10;
   localparam logic [1:0] DIV   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shared multiply/divide datapath.
//   acc_i  [2W:0] : accumulator; upper W+1 bits = partial sum / partial remainder,
//                   lower W bits = multiplier being consumed / dividend being shifted in
//   opnd_i [W-1:0]: multiplicand or divisor magnitude
//   is_div_i      : selects a restoring-divide step (present only with MULDIV_DIV_EN)
//   acc_o  [2W:0] : accumulator after this step
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [2*WIDTH:0] acc_i,
   input  logic [WIDTH-1:0] opnd_i,
`ifdef MULDIV_DIV_EN
   input  logic             is_div_i,
`endif
   output logic [2*WIDTH:0] acc_o
);

   logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0] rem;
`endif

   always_comb begin
      // Shift-add multiply: add the multiplicand when the multiplier LSB is set,
      // then shift the whole accumulator right. The carry lands in bit W of the
      // upper half, so the top bit is always zero after the shift.
      sum   = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, opnd_i} : '0);
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      // Restoring divide: shift {rem, dividend} left one bit, then subtract the
      // divisor when it fits and shift a 1 into the quotient.
      rem = acc_i[2*WIDTH-1:WIDTH-1];
      if (is_div_i) begin
         if (rem >= {1'b0, opnd_i})
            acc_o = {rem - {1'b0, opnd_i}, acc_i[WIDTH-2:0], 1'b1};
         else
            acc_o = {rem, acc_i[WIDTH-2:0], 1'b0};
      end
`endif
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the iterative HI/LO multiply (and optional divide) unit.
//   clk, reset_n           : clock, asynchronous active-low reset
//   multstartE, opE        : start request and op (00 multu, 01 mult, 10 divu, 11 div)
//   srcaE, srcbE           : operands (rs, rt)
//   hilo_rdD               : mfhi/mflo in Decode
//   mthi_we, mtlo_we       : move-to HI/LO strobes, mt_data their data
//   hi, lo                 : architectural HI/LO registers
//   busy                   : operation in flight
//   pve                    : one-cycle pulse, new HI/LO valid
//   hilo_stall, mt_stall   : Decode read / move-to write blocked by busy unit
// Define MULDIV_DIV_EN to include the restoring divider; without it, divide
// starts are dropped.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             multstartE,
   input  logic [1:0]       opE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             hilo_rdD,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] mt_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             pve,
   output logic             hilo_stall,
   output logic             mt_stall
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               neg_q, neg_d;      // sign of product / quotient
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               pve_q, pve_d;
`ifdef MULDIV_DIV_EN
   logic               is_div_q, is_div_d;
   logic               neg_r_q, neg_r_d;  // sign of remainder (dividend sign)
   logic               dz_q, dz_d;        // divide by zero: quotient stays all ones
`endif

   logic               start_ok;
   logic               sa, sb;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH:0]   step_acc;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
`ifdef MULDIV_DIV_EN
      .is_div_i (is_div_q),
`endif
      .acc_o    (step_acc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pve_d   = 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_d = is_div_q;
      neg_r_d  = neg_r_q;
      dz_d     = dz_q;
      start_ok = multstartE;
`else
      start_ok = multstartE & ~opE[1];
`endif
      // Magnitudes: only signed ops (opE[0]) take the absolute value.
      sa    = opE[0] & srcaE[WIDTH-1];
      sb    = opE[0] & srcbE[WIDTH-1];
      abs_a = sa ? -srcaE : srcaE;
      abs_b = sb ? -srcbE : srcbE;
      prod  = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];

      case (state_q)
         IDLE: begin
            // Move-to writes commit here even alongside a start; FIX overwrites later.
            if (mthi_we) hi_d = mt_data;
            if (mtlo_we) lo_d = mt_data;
            if (start_ok) begin
               state_d = RUN;
               cnt_d   = '0;
               acc_d   = {1'b0, {WIDTH{1'b0}}, abs_a};
               opnd_d  = abs_b;
               neg_d   = sa ^ sb;
`ifdef MULDIV_DIV_EN
               is_div_d = opE[1];
               neg_r_d  = sa;
               dz_d     = (srcbE == '0);
`endif
            end
         end
         RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            // Multiply negates the full 2W product; divide negates each half alone.
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               lo_d = (neg_q & ~dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
`endif
            pve_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         pve_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div_q <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         pve_q    <= pve_d;
`ifdef MULDIV_DIV_EN
         is_div_q <= is_div_d;
         neg_r_q  <= neg_r_d;
         dz_q     <= dz_d;
`endif
      end
   end

   assign hi         = hi_q;
   assign lo         = lo_q;
   assign pve        = pve_q;
   assign busy       = (state_q != IDLE);
   assign hilo_stall = hilo_rdD & busy;
   assign mt_stall   = (mthi_we | mtlo_we) & busy;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl (WIDTH = 32).
// Divide cases are compiled when MULDIV_DIV_EN is defined; otherwise the bench
// checks that a divide start is dropped.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        multstartE;
   logic [1:0]  opE;
   logic [31:0] srcaE, srcbE;
   logic        hilo_rdD;
   logic        mthi_we, mtlo_we;
   logic [31:0] mt_data;
   logic [31:0] hi, lo;
   logic        busy, pve, hilo_stall, mt_stall;

   int n_cmp = 0;
   int n_bad = 0;
   int lat, bcnt, k, sc, pcnt;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .multstartE (multstartE),
      .opE        (opE),
      .srcaE      (srcaE),
      .srcbE      (srcbE),
      .hilo_rdD   (hilo_rdD),
      .mthi_we    (mthi_we),
      .mtlo_we    (mtlo_we),
      .mt_data    (mt_data),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .pve        (pve),
      .hilo_stall (hilo_stall),
      .mt_stall   (mt_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the start is sampled at the next posedge (edge N).
   // Returns at the first negedge after edge N.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      multstartE = 1'b1;
      opE        = op;
      srcaE      = a;
      srcbE      = b;
      @(negedge clk);
      multstartE = 1'b0;
   endtask

   // Counts edges after the start edge until pve, and busy cycles on the way.
   task automatic wait_pve(output int l, output int bc);
      l  = 0;
      bc = 0;
      while (pve !== 1'b1 && l < 100) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         l++;
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      multstartE = 1'b0;
      opE        = 2'b00;
      srcaE      = '0;
      srcbE      = '0;
      hilo_rdD   = 1'b0;
      mthi_we    = 1'b0;
      mtlo_we    = 1'b0;
      mt_data    = '0;

      // Reset state
      @(negedge clk);
      chk("rst_hi",   64'(hi), 64'h0);
      chk("rst_lo",   64'(lo), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_pve",  64'(pve), 64'h0);
      chk("rst_hstl", 64'(hilo_stall), 64'h0);
      chk("rst_mstl", 64'(mt_stall), 64'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // multu full range
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_busy0", 64'(busy), 64'h1);
      wait_pve(lat, bcnt);
      chk("multu_lat",  64'(lat), 64'd33);
      chk("multu_bcnt", 64'(bcnt), 64'd33);
      chk("multu_busy_at_pve", 64'(busy), 64'h0);
      chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      chk("multu_lo", 64'(lo), 64'h0000_0001);

      // mult signed -3 x 5, started right in the pve cycle
      start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
      chk("pve_one_cycle", 64'(pve), 64'h0);
      wait_pve(lat, bcnt);
      chk("mult_neg_lat", 64'(lat), 64'd33);
      chk("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFF1);

      // Back-to-back start in the pve cycle: 7 x 6
      start_op(2'b01, 32'd7, 32'd6);
      chk("b2b_busy", 64'(busy), 64'h1);
      chk("b2b_hi_hold", 64'(hi), 64'hFFFF_FFFF);
      wait_pve(lat, bcnt);
      chk("b2b_lat", 64'(lat), 64'd33);
      chk("b2b_hi", 64'(hi), 64'h0);
      chk("b2b_lo", 64'(lo), 64'h2A);

      // Most-negative squared (signed): 2^62
      start_op(2'b01, 32'h8000_0000, 32'h8000_0000);
      wait_pve(lat, bcnt);
      chk("mult_min_hi", 64'(hi), 64'h4000_0000);
      chk("mult_min_lo", 64'(lo), 64'h0);

      // -1 x -1 signed
      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_pve(lat, bcnt);
      chk("mult_m1_hi", 64'(hi), 64'h0);
      chk("mult_m1_lo", 64'(lo), 64'h1);

      // Set LO to 0x2A again as a known value for the hold check below
      start_op(2'b00, 32'd7, 32'd6);
      wait_pve(lat, bcnt);

      // Stall outputs, ignored second start, move-to during RUN: 100 x 200
      hilo_rdD = 1'b1;
      start_op(2'b00, 32'd100, 32'd200);
      k  = 0;
      sc = 0;
      while (pve !== 1'b1 && k < 100) begin
         if (hilo_stall === 1'b1) sc++;
         if (k == 5) begin
            multstartE = 1'b1;
            srcaE      = 32'd1;
            srcbE      = 32'd1;
         end
         if (k == 6) multstartE = 1'b0;
         if (k == 10) begin
            mtlo_we = 1'b1;
            mt_data = 32'hDEAD;
            #1;
            chk("mt_stall_run", 64'(mt_stall), 64'h1);
         end
         if (k == 11) begin
            mtlo_we = 1'b0;
            chk("lo_hold_run", 64'(lo), 64'h2A);
         end
         @(negedge clk);
         k++;
      end
      chk("stall_lat", 64'(k), 64'd33);
      chk("stall_cnt", 64'(sc), 64'd33);
      chk("stall_off_at_pve", 64'(hilo_stall), 64'h0);
      chk("stall_lo", 64'(lo), 64'h4E20);
      chk("stall_hi", 64'(hi), 64'h0);
      hilo_rdD = 1'b0;

      // Reset asserted mid-run
      start_op(2'b00, 32'hFFFF_FFFF, 32'd2);
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 64'h1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'h0);
      chk("mid_rst_hi", 64'(hi), 64'h0);
      chk("mid_rst_lo", 64'(lo), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      pcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pve === 1'b1 || busy === 1'b1) pcnt++;
      end
      chk("post_rst_quiet", 64'(pcnt), 64'd0);

      // Move-to in IDLE
      mthi_we = 1'b1;
      mt_data = 32'h1234;
      #1;
      chk("mt_stall_idle", 64'(mt_stall), 64'h0);
      @(negedge clk);
      mthi_we = 1'b0;
      chk("mthi_hi", 64'(hi), 64'h1234);
      chk("mthi_lo", 64'(lo), 64'h0);
      mthi_we = 1'b1;
      mtlo_we = 1'b1;
      mt_data = 32'h55;
      @(negedge clk);
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      chk("mt_both_hi", 64'(hi), 64'h55);
      chk("mt_both_lo", 64'(lo), 64'h55);

      // Move-to in the same cycle as a start: write lands, FIX overwrites
      mtlo_we = 1'b1;
      mt_data = 32'hABCD;
      start_op(2'b00, 32'd3, 32'd4);
      mtlo_we = 1'b0;
      chk("mt_start_lo", 64'(lo), 64'hABCD);
      chk("mt_start_hi", 64'(hi), 64'h55);
      wait_pve(lat, bcnt);
      chk("mt_start_res_lo", 64'(lo), 64'hC);
      chk("mt_start_res_hi", 64'(hi), 64'h0);

`ifdef MULDIV_DIV_EN
      // div -7 / 2: quotient -3, remainder -1
      start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_pve(lat, bcnt);
      chk("div_lat", 64'(lat), 64'd33);
      chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
      // divu 9 / 0
      start_op(2'b10, 32'd9, 32'd0);
      wait_pve(lat, bcnt);
      chk("divz_lat", 64'(lat), 64'd33);
      chk("divz_hi", 64'(hi), 64'h9);
      chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
      // div most-negative / -1
      start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_pve(lat, bcnt);
      chk("divmin_lo", 64'(lo), 64'h8000_0000);
      chk("divmin_hi", 64'(hi), 64'h0);
      // divu 100 / 7: q 14, r 2
      start_op(2'b10, 32'd100, 32'd7);
      wait_pve(lat, bcnt);
      chk("divu_lo", 64'(lo), 64'd14);
      chk("divu_hi", 64'(hi), 64'd2);
`else
      // Divide start without the divider: dropped entirely
      start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
      chk("nodiv_busy", 64'(busy), 64'h0);
      pcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pve === 1'b1 || busy === 1'b1) pcnt++;
      end
      chk("nodiv_quiet", 64'(pcnt), 64'd0);
      chk("nodiv_hi", 64'(hi), 64'h0);
      chk("nodiv_lo", 64'(lo), 64'hC);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the iterative HI/LO multiply unit in the Execute stage. Accepts a start pulse from E and runs a radix-2 shift-add datapath for WIDTH steps. Applies sign correction, then writes HI/LO and pulses `pve` so the hazard unit can release its multiply stall. It also arbitrates `mthi`/`mtlo` writes and `mfhi`/`mflo` reads against an operation in flight.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `multstartE` in 1: start request, sampled only in IDLE.
- `opE` in 2: operation. 00 multu, 01 mult, 10 divu, 11 div.
- `srcaE`, `srcbE` in WIDTH: operands (rs, rt).
- `hilo_rdD` in 1: an `mfhi`/`mflo` instruction is in the D stage.
- `mthi_we`, `mtlo_we` in 1: move-to HI/LO write strobes.
- `mt_data` in WIDTH: data for the move-to writes.
- `hi`, `lo` out WIDTH: architectural HI/LO. Reset value 0.
- `busy` out 1: asserted when state != IDLE. Reset value 0.
- `pve` out 1: registered one-cycle pulse; new HI/LO are valid in this cycle. Reset value 0.
- `hilo_stall` out 1: equals `hilo_rdD & busy`. Reset value 0.
- `mt_stall` out 1: equals `(mthi_we | mtlo_we) & busy`. Reset value 0.

## Operation
The controller has three states.
- **IDLE → RUN** on `multstartE`.
  - Latch |srcaE| and |srcbE|; apply the absolute value only for signed ops.
  - Latch result sign: sa^sb for the product and quotient; sa for the remainder.
  - Clear the accumulator; set `cnt` = 0.
- **RUN**: perform one datapath step per cycle and increment `cnt`. Go to FIX when `cnt` == WIDTH-1.
- **FIX**: negate the result halves as required, write HI/LO, set `pve` for the next cycle, go to IDLE.

Result placement:
- Multiply: HI = upper half of the 2·WIDTH product, LO = lower half.
- Divide: LO = quotient, HI = remainder.

Arithmetic rules:
- All internal arithmetic is unsigned, WIDTH+1 bits for the divider partial remainder.
- The product is 2·WIDTH bits; no overflow is possible.
- Most-negative / −1 division yields quotient 0x80000000 and remainder 0 (natural result of the unsigned-magnitude path).

Boundary conditions:
- `multstartE` while busy: ignored. The hazard unit guarantees this cannot occur.
- Move-to writes are accepted only in IDLE and can be simultaneous (HI and LO both written). In RUN or FIX they are ignored and `mt_stall` is raised.
- A move-to write in the same cycle as an IDLE start: the write commits, and the operation later overwrites HI/LO in FIX.
- Reset asserted mid-operation: abort immediately. State goes to IDLE, HI/LO to 0, no `pve`.

## Timing
- Start sampled at edge N. Steps occur at edges N+1..N+WIDTH. FIX write at edge N+WIDTH+1.
- `pve` is high in cycle N+WIDTH+1, i.e. 33 cycles after the start for WIDTH=32.
- `busy` rises after edge N and falls after edge N+WIDTH+1, coincident with `pve`.
- A back-to-back start can be sampled in the `pve` cycle.
- HI/LO outputs are registered. Old values stay stable until the FIX edge.

## Configuration
Macro `MULDIV_DIV_EN`:
- **Defined**: ops 10/11 run a restoring divider through the same RUN/FIX sequence. Divide by zero writes HI = dividend, LO = all ones, with normal latency.
- **Undefined**: the divider logic is absent. A start with `opE[1]`=1 is ignored: no state change, no `pve`, HI/LO unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - the op encoding constants (MULTU, MULT, DIVU, DIV);
  - the state typedef (IDLE, RUN, FIX);
  - the default WIDTH;
  - the counter width, `$clog2(WIDTH)`.
- Sub-module `muldiv_step` is combinational: one multiply or divide iteration (accumulator, shifted operand, op) → next accumulator. The controller holds the FSM, the counter, the sign bits and HI/LO.

## Test plan
- **multu full range**: 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, `pve` exactly 33 cycles after start, `busy` high for 33 cycles.
- **mult signed**: −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Back-to-back start in the `pve` cycle with 7 × 6 → LO=0x2A, 33 cycles later.
- **Stall outputs**: `hilo_rdD` held during RUN → `hilo_stall`=1 every cycle until `pve`, then 0. A second `multstartE` at cycle 5 is ignored: result and timing unchanged.
- **Reset mid-run**: `reset_n` low for one cycle at cycle 10 of RUN → `busy`=0 and HI=LO=0 asynchronously, no `pve` afterwards.
- **Move-to**: `mthi_we` with 0x1234 in IDLE → HI=0x1234 next cycle. `mtlo_we` during RUN → LO unchanged, `mt_stall`=1.
- **With `MULDIV_DIV_EN`**: div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 9 / 0 → HI=9, LO=0xFFFFFFFF. Without the macro, div start → `busy` stays 0.
